// File: rtl/mem_access.sv
// mem_access: memory stage of the pipeline. It owns the byte-writable data
// SRAM, performs byte-lane merges on stores, extracts and extends load data,
// and passes non-memory results through to writeback.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   EX_MEM_addr         byte address (word index = addr[AW+1:2])
//   EX_MEM_rden         read lane mask, EX_MEM_rden_SEXT sign-extends loads
//   EX_MEM_wren         write lane mask, EX_MEM_wrdata lane-replicated data
//   EX_rd, EX_rd_vld    destination register and valid
//   EX_x_rd             non-memory result from Execute
//   MEM_busy            combinational stall toward Execute
//   MEM_rd, MEM_rd_vld  registered writeback destination and valid
//   MEM_x_rd            registered writeback data
//   MEM_err             registered one-cycle pulse on an illegal request
module mem_access #(
  parameter int DEPTH       = 1024,
  parameter int AW          = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] EX_MEM_addr,
  input  logic [3:0]  EX_MEM_rden,
  input  logic        EX_MEM_rden_SEXT,
  input  logic [3:0]  EX_MEM_wren,
  input  logic [31:0] EX_MEM_wrdata,
  input  logic [4:0]  EX_rd,
  input  logic        EX_rd_vld,
  input  logic [31:0] EX_x_rd,
  output logic        MEM_busy,
  output logic [4:0]  MEM_rd,
  output logic        MEM_rd_vld,
  output logic [31:0] MEM_x_rd,
  output logic        MEM_err
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic       HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH];

  logic          req, illegal, access, do_store, rd_ok;
  logic [AW-1:0] widx;
  logic [31:0]   rword, ldval;
  logic [31:0]   res_x;
  logic [4:0]    res_rd;
  logic          res_vld, res_err;
  logic          unused_addr;

  function automatic logic mask_ok(input logic [3:0] m);
    case (m)
      4'b1111, 4'b0011, 4'b1100,
      4'b0001, 4'b0010, 4'b0100, 4'b1000: mask_ok = 1'b1;
      default:                            mask_ok = 1'b0;
    endcase
  endfunction

  assign widx        = EX_MEM_addr[AW+1:2];
  assign unused_addr = ^{EX_MEM_addr[31:AW+2], EX_MEM_addr[1:0]};
  assign req         = (|EX_MEM_rden) | (|EX_MEM_wren);
  // A zero mask is fine for the other direction; only nonzero masks must be legal.
  assign illegal     = ((|EX_MEM_rden) & (|EX_MEM_wren))
                     | ((|EX_MEM_rden) & ~mask_ok(EX_MEM_rden))
                     | ((|EX_MEM_wren) & ~mask_ok(EX_MEM_wren));
  assign rd_ok       = EX_rd_vld & (EX_rd != 5'd0);

  assign MEM_busy = ((state == IDLE) & req & HAS_WAIT) | ((state == WAIT) & (cnt > 4'd1));
  assign access   = ((state == IDLE) & req & ~HAS_WAIT) | ((state == WAIT) & (cnt == 4'd1));
  // Gating with rst_n keeps a reset that lands on the access cycle from writing.
  assign do_store = access & ~illegal & (|EX_MEM_wren) & rst_n;

  assign rword = mem[widx];

  always_comb begin
    ldval = '0;
    case (EX_MEM_rden)
      4'b1111: ldval = rword;
      4'b0011: ldval = {{16{EX_MEM_rden_SEXT & rword[15]}}, rword[15:0]};
      4'b1100: ldval = {{16{EX_MEM_rden_SEXT & rword[31]}}, rword[31:16]};
      4'b0001: ldval = {{24{EX_MEM_rden_SEXT & rword[7]}},  rword[7:0]};
      4'b0010: ldval = {{24{EX_MEM_rden_SEXT & rword[15]}}, rword[15:8]};
      4'b0100: ldval = {{24{EX_MEM_rden_SEXT & rword[23]}}, rword[23:16]};
      4'b1000: ldval = {{24{EX_MEM_rden_SEXT & rword[31]}}, rword[31:24]};
      default: ldval = '0;
    endcase
  end

  // Writeback values produced by an access cycle.
  always_comb begin
    res_x   = '0;
    res_rd  = '0;
    res_vld = 1'b0;
    res_err = 1'b0;
    if (illegal) begin
      res_err = 1'b1;
    end else if (|EX_MEM_wren) begin
      res_rd = EX_rd;
    end else begin
      res_x   = ldval;
      res_rd  = EX_rd;
      res_vld = rd_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (EX_MEM_wren[i]) mem[widx][8*i +: 8] <= EX_MEM_wrdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      MEM_rd     <= '0;
      MEM_rd_vld <= 1'b0;
      MEM_x_rd   <= '0;
      MEM_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!req) begin
            MEM_x_rd   <= EX_x_rd;
            MEM_rd     <= EX_rd;
            MEM_rd_vld <= rd_ok;
            MEM_err    <= 1'b0;
          end else if (HAS_WAIT) begin
            state      <= WAIT;
            cnt        <= WAIT_INIT;
            MEM_x_rd   <= '0;
            MEM_rd     <= '0;
            MEM_rd_vld <= 1'b0;
            MEM_err    <= 1'b0;
          end else begin
            MEM_x_rd   <= res_x;
            MEM_rd     <= res_rd;
            MEM_rd_vld <= res_vld;
            MEM_err    <= res_err;
          end
        end
        WAIT: begin
          if (cnt > 4'd1) begin
            cnt        <= cnt - 4'd1;
            MEM_x_rd   <= '0;
            MEM_rd     <= '0;
            MEM_rd_vld <= 1'b0;
            MEM_err    <= 1'b0;
          end else begin
            state      <= IDLE;
            cnt        <= '0;
            MEM_x_rd   <= res_x;
            MEM_rd     <= res_rd;
            MEM_rd_vld <= res_vld;
            MEM_err    <= res_err;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // dut0: WAIT_CYCLES=0
  logic        a_rst_n;
  logic [31:0] a_addr, a_wrdata, a_x;
  logic [3:0]  a_rden, a_wren;
  logic        a_sext, a_rd_vld;
  logic [4:0]  a_rd;
  logic        a_busy, a_mvld, a_err;
  logic [4:0]  a_mrd;
  logic [31:0] a_mx;

  // dut2: WAIT_CYCLES=2
  logic        b_rst_n;
  logic [31:0] b_addr, b_wrdata, b_x;
  logic [3:0]  b_rden, b_wren;
  logic        b_sext, b_rd_vld;
  logic [4:0]  b_rd;
  logic        b_busy, b_mvld, b_err;
  logic [4:0]  b_mrd;
  logic [31:0] b_mx;

  mem_access #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(a_rst_n), .EX_MEM_addr(a_addr), .EX_MEM_rden(a_rden),
    .EX_MEM_rden_SEXT(a_sext), .EX_MEM_wren(a_wren), .EX_MEM_wrdata(a_wrdata),
    .EX_rd(a_rd), .EX_rd_vld(a_rd_vld), .EX_x_rd(a_x), .MEM_busy(a_busy),
    .MEM_rd(a_mrd), .MEM_rd_vld(a_mvld), .MEM_x_rd(a_mx), .MEM_err(a_err)
  );

  mem_access #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(b_rst_n), .EX_MEM_addr(b_addr), .EX_MEM_rden(b_rden),
    .EX_MEM_rden_SEXT(b_sext), .EX_MEM_wren(b_wren), .EX_MEM_wrdata(b_wrdata),
    .EX_rd(b_rd), .EX_rd_vld(b_rd_vld), .EX_x_rd(b_x), .MEM_busy(b_busy),
    .MEM_rd(b_mrd), .MEM_rd_vld(b_mvld), .MEM_x_rd(b_mx), .MEM_err(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Applies one request to dut0 at a negedge, checks it does not stall,
  // and returns at the next negedge with the registered result visible.
  task automatic a_req(input string tag, input logic [31:0] addr, input logic [3:0] rden,
                       input logic sext, input logic [3:0] wren, input logic [31:0] wdata,
                       input logic [4:0] rd, input logic vld, input logic [31:0] x);
    a_addr = addr; a_rden = rden; a_sext = sext; a_wren = wren; a_wrdata = wdata;
    a_rd = rd; a_rd_vld = vld; a_x = x;
    #1;
    chk({tag, "_busy"}, {31'd0, a_busy}, 32'd0);
    @(negedge clk);
  endtask

  task automatic b_set(input logic [31:0] addr, input logic [3:0] rden,
                       input logic [3:0] wren, input logic [31:0] wdata,
                       input logic [4:0] rd, input logic vld);
    b_addr = addr; b_rden = rden; b_sext = 1'b0; b_wren = wren; b_wrdata = wdata;
    b_rd = rd; b_rd_vld = vld; b_x = 32'h0;
  endtask

  // Runs a full WAIT_CYCLES=2 request on dut2, checking the busy/bubble timing.
  task automatic b_req(input string tag, input logic [31:0] addr, input logic [3:0] rden,
                       input logic [3:0] wren, input logic [31:0] wdata,
                       input logic [4:0] rd, input logic vld);
    b_set(addr, rden, wren, wdata, rd, vld);
    #1;
    chk({tag, "_busyT"}, {31'd0, b_busy}, 32'd1);
    @(negedge clk);
    chk({tag, "_busyT1"}, {31'd0, b_busy}, 32'd1);
    chk({tag, "_vldT1"}, {31'd0, b_mvld}, 32'd0);
    @(negedge clk);
    chk({tag, "_busyT2"}, {31'd0, b_busy}, 32'd0);
    chk({tag, "_vldT2"}, {31'd0, b_mvld}, 32'd0);
    @(negedge clk);
    b_set(32'h0, 4'b0000, 4'b0000, 32'h0, 5'd0, 1'b0);
  endtask

  initial begin
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_addr = '0; a_rden = '0; a_sext = 1'b0; a_wren = '0; a_wrdata = '0;
    a_rd = '0; a_rd_vld = 1'b0; a_x = '0;
    b_set(32'h0, 4'b0000, 4'b0000, 32'h0, 5'd0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_x", a_mx, 32'h0);
    chk("rst_rd", {27'd0, a_mrd}, 32'h0);
    chk("rst_vld", {31'd0, a_mvld}, 32'h0);
    chk("rst_err", {31'd0, a_err}, 32'h0);
    chk("rst2_vld", {31'd0, b_mvld}, 32'h0);
    a_rst_n = 1'b1; b_rst_n = 1'b1;

    // WAIT_CYCLES=0 directed vectors
    a_req("sw", 32'h10, 4'b0000, 1'b0, 4'b1111, 32'hDEADBEEF, 5'd0, 1'b0, 32'h0);
    chk("sw_vld", {31'd0, a_mvld}, 32'd0);
    chk("sw_err", {31'd0, a_err}, 32'd0);
    a_req("lw", 32'h10, 4'b1111, 1'b0, 4'b0000, 32'h0, 5'd5, 1'b1, 32'h0);
    chk("lw_x", a_mx, 32'hDEADBEEF);
    chk("lw_rd", {27'd0, a_mrd}, 32'd5);
    chk("lw_vld", {31'd0, a_mvld}, 32'd1);
    a_req("lb", 32'h13, 4'b1000, 1'b1, 4'b0000, 32'h0, 5'd6, 1'b1, 32'h0);
    chk("lb_x", a_mx, 32'hFFFFFFDE);
    a_req("lbu", 32'h13, 4'b1000, 1'b0, 4'b0000, 32'h0, 5'd6, 1'b1, 32'h0);
    chk("lbu_x", a_mx, 32'h000000DE);
    a_req("lh", 32'h12, 4'b1100, 1'b1, 4'b0000, 32'h0, 5'd6, 1'b1, 32'h0);
    chk("lh_x", a_mx, 32'hFFFFDEAD);
    a_req("lhu", 32'h10, 4'b0011, 1'b0, 4'b0000, 32'h0, 5'd6, 1'b1, 32'h0);
    chk("lhu_x", a_mx, 32'h0000BEEF);
    a_req("sb", 32'h11, 4'b0000, 1'b0, 4'b0010, 32'h55555555, 5'd0, 1'b0, 32'h0);
    chk("sb_vld", {31'd0, a_mvld}, 32'd0);
    a_req("lw2", 32'h10, 4'b1111, 1'b0, 4'b0000, 32'h0, 5'd9, 1'b1, 32'h0);
    chk("lw2_x", a_mx, 32'hDEAD55EF);
    a_req("alias", 32'h10 + 32'd4096, 4'b1111, 1'b0, 4'b0000, 32'h0, 5'd9, 1'b1, 32'h0);
    chk("alias_x", a_mx, 32'hDEAD55EF);
    a_req("nm0", 32'h0, 4'b0000, 1'b0, 4'b0000, 32'h0, 5'd0, 1'b1, 32'h1234);
    chk("nm0_vld", {31'd0, a_mvld}, 32'd0);
    a_req("nm7", 32'h0, 4'b0000, 1'b0, 4'b0000, 32'h0, 5'd7, 1'b1, 32'h1234);
    chk("nm7_vld", {31'd0, a_mvld}, 32'd1);
    chk("nm7_x", a_mx, 32'h1234);
    chk("nm7_rd", {27'd0, a_mrd}, 32'd7);
    a_req("ill", 32'h10, 4'b0101, 1'b0, 4'b0000, 32'h0, 5'd7, 1'b1, 32'h1234);
    chk("ill_err", {31'd0, a_err}, 32'd1);
    chk("ill_vld", {31'd0, a_mvld}, 32'd0);
    chk("ill_x", a_mx, 32'h0);
    a_req("ill2", 32'h10, 4'b1111, 1'b0, 4'b1111, 32'h0, 5'd7, 1'b1, 32'h0);
    chk("ill2_err", {31'd0, a_err}, 32'd1);
    a_req("post", 32'h10, 4'b1111, 1'b0, 4'b0000, 32'h0, 5'd3, 1'b1, 32'h0);
    chk("post_err", {31'd0, a_err}, 32'd0);
    chk("post_x", a_mx, 32'hDEAD55EF);

    // WAIT_CYCLES=2 directed vectors
    b_req("sw2", 32'h20, 4'b0000, 4'b1111, 32'h13572468, 5'd0, 1'b0);
    chk("sw2_vld", {31'd0, b_mvld}, 32'd0);
    b_req("lw2w", 32'h20, 4'b1111, 4'b0000, 32'h0, 5'd4, 1'b1);
    chk("lw2w_vld", {31'd0, b_mvld}, 32'd1);
    chk("lw2w_x", b_mx, 32'h13572468);
    chk("lw2w_rd", {27'd0, b_mrd}, 32'd4);
    @(negedge clk);
    // store aborted by reset during its wait
    b_set(32'h20, 4'b0000, 4'b1111, 32'hFFFFFFFF, 5'd0, 1'b0);
    @(negedge clk);
    b_rst_n = 1'b0;
    @(negedge clk);
    chk("rstw_x", b_mx, 32'h0);
    chk("rstw_vld", {31'd0, b_mvld}, 32'd0);
    chk("rstw_err", {31'd0, b_err}, 32'd0);
    chk("rstw_busy", {31'd0, b_busy}, 32'd1);
    b_rst_n = 1'b1;
    b_req("lwold", 32'h20, 4'b1111, 4'b0000, 32'h0, 5'd8, 1'b1);
    chk("lwold_x", b_mx, 32'h13572468);
    chk("lwold_vld", {31'd0, b_mvld}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
